// File: rtl/cpu_step_ctrl.sv
// Button debouncer: two-flop synchroniser, stable-count filter, one-cycle pulse on press.
// Latency: press pulse 2 + DEBOUNCE_CYCLES cycles after a stable low on the raw input.
// Backpressure: none; releases and short bounces produce no pulse.
module cpu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw_n,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;

    assign w_differ = (r_s2 != r_level);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= i_raw_n;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

// CPU execution control: run/halt/break FSM issuing a one-cycle cpu_ce advance pulse.
// Latency: cpu_ce registered 1 cycle after a press pulse; RUN pulses every active period.
// Backpressure: none; a run press in the pulse cycle drops that pulse.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SLOW_PERIOD     = 8_388_608,
    parameter int FAST_PERIOD     = 1_048_576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_btn_n,
    input  logic        step_btn_n,
    input  logic        fast_sw,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] pc_in,
    output logic        cpu_ce,
    output logic        running,
    output logic        bp_hit,
    output logic [15:0] step_count
);
    localparam logic [24:0] SLOW_LAST = 25'(SLOW_PERIOD - 1);
    localparam logic [24:0] FAST_LAST = 25'(FAST_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [24:0] r_pace;
    logic [24:0] w_pace_nxt;
    logic        r_skip_bp;
    logic        w_skip_nxt;
    logic        r_ce;
    logic        w_ce_nxt;
    logic [15:0] r_step_count;
    logic        r_fast_s1;
    logic        r_fast_s2;
    logic        w_run_press;
    logic        w_step_press;
    logic [24:0] w_period_last;
    logic        w_pace_due;
    logic        w_bp_match;

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk     (clk),
        .reset   (reset),
        .i_raw_n (run_btn_n),
        .o_press (w_run_press)
    );

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk     (clk),
        .reset   (reset),
        .i_raw_n (step_btn_n),
        .o_press (w_step_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fast_s1 <= 1'b0;
            r_fast_s2 <= 1'b0;
        end else begin
            r_fast_s1 <= fast_sw;
            r_fast_s2 <= r_fast_s1;
        end
    end

    // >= rather than == so a rate switch to a shorter period fires at once instead of wrapping.
    assign w_period_last = r_fast_s2 ? FAST_LAST : SLOW_LAST;
    assign w_pace_due    = (r_pace >= w_period_last);
    assign w_bp_match    = bp_en && (pc_in == bp_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_pace_nxt  = r_pace;
        w_skip_nxt  = r_skip_bp;
        w_ce_nxt    = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (w_run_press) begin
                    w_state_nxt = ST_RUN;
                    w_pace_nxt  = '0;
                    w_skip_nxt  = 1'b0;
                end else if (w_step_press) begin
                    w_ce_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_pace_nxt = r_pace + 1'b1;
                if (w_run_press) begin
                    w_state_nxt = ST_HALT;
                end else if (w_pace_due) begin
                    if (w_bp_match && !r_skip_bp) begin
                        w_state_nxt = ST_BREAK;
                    end else begin
                        w_ce_nxt   = 1'b1;
                        w_pace_nxt = '0;
                        w_skip_nxt = 1'b0;
                    end
                end
            end
            ST_BREAK: begin
                // Resuming sets skip_bp so the PC we stopped on is executed, not re-trapped.
                if (w_run_press) begin
                    w_state_nxt = ST_RUN;
                    w_pace_nxt  = '0;
                    w_skip_nxt  = 1'b1;
                end else if (w_step_press) begin
                    w_ce_nxt    = 1'b1;
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HALT;
            r_pace       <= '0;
            r_skip_bp    <= 1'b0;
            r_ce         <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pace    <= w_pace_nxt;
            r_skip_bp <= w_skip_nxt;
            r_ce      <= w_ce_nxt;
            if (w_ce_nxt) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

    assign cpu_ce     = r_ce;
    assign running    = (r_state == ST_RUN);
    assign bp_hit     = (r_state == ST_BREAK);
    assign step_count = r_step_count;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: expected cpu_ce pulses (cycle, step_count) are queued by the
// stimulus and matched by a monitor on every observed pulse.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        run_btn_n;
    logic        step_btn_n;
    logic        fast_sw;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] pc_in = 16'h0000;
    logic        cpu_ce;
    logic        running;
    logic        bp_hit;
    logic [15:0] step_count;
    logic        pc_load;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    logic prev_ce = 1'b0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SLOW_PERIOD     (10),
        .FAST_PERIOD     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_btn_n  (run_btn_n),
        .step_btn_n (step_btn_n),
        .fast_sw    (fast_sw),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_in      (pc_in),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .bp_hit     (bp_hit),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CPU model: PC advances only after an issued cpu_ce.
    always @(posedge clk) begin
        if (pc_load)     pc_in <= 16'h0200;
        else if (cpu_ce) pc_in <= pc_in + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ce(input int at, input logic [15:0] cnt);
        exp_t x;
        x.at  = at;
        x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && cyc > int'(exp_q[0].at)) begin
            e = exp_q.pop_front();
            check($sformatf("ce_missing_at_%0d", e.at), 32'd0, 32'd1);
        end
        if (cpu_ce) begin
            check("ce_not_back_to_back", {31'd0, prev_ce}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ce", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ce_cycle", cyc, e.at);
                check("ce_step_count", {16'd0, step_count}, {16'd0, e.cnt});
            end
        end
        prev_ce = cpu_ce;
    end

    initial begin
        int c;
        int e;
        reset      = 1'b1;
        run_btn_n  = 1'b1;
        step_btn_n = 1'b1;
        fast_sw    = 1'b0;
        bp_en      = 1'b0;
        bp_addr    = 16'h0000;
        pc_load    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("rst_step_count", {16'd0, step_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bounce: 2 low / 2 high never reaches the 4-cycle stability threshold.
        for (int i = 0; i < 5; i++) begin
            step_btn_n = 1'b0;
            repeat (2) @(negedge clk);
            step_btn_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        check("bounce_step_count", {16'd0, step_count}, 32'd0);

        // Single step: pulse 7 edges after the first edge that samples the low level.
        c = cyc;
        expect_ce(c + 8, 16'd1);
        step_btn_n = 1'b0;
        repeat (10) @(negedge clk);
        step_btn_n = 1'b1;
        repeat (15) @(negedge clk);
        check("step_running", {31'd0, running}, 32'd0);
        check("step_step_count", {16'd0, step_count}, 32'd1);

        // Run pacing: slow 10, then fast 3, then stop on a pulse cycle (pulse dropped).
        c = cyc;
        e = c + 8;
        expect_ce(e + 10, 16'd2);
        expect_ce(e + 20, 16'd3);
        expect_ce(e + 23, 16'd4);
        expect_ce(e + 26, 16'd5);
        expect_ce(e + 29, 16'd6);
        run_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n = 1'b1;
        wait_cyc(e + 5);
        check("run_running", {31'd0, running}, 32'd1);
        wait_cyc(e + 20);
        fast_sw = 1'b1;
        wait_cyc(e + 24);
        run_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n = 1'b1;
        wait_cyc(e + 31);
        check("run_still_running", {31'd0, running}, 32'd1);
        wait_cyc(e + 32);
        check("stop_running", {31'd0, running}, 32'd0);
        wait_cyc(e + 45);
        check("stop_step_count", {16'd0, step_count}, 32'd6);
        fast_sw = 1'b0;

        // Breakpoint at 0x0203 after a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 16'h0203;
        repeat (3) @(negedge clk);
        c = cyc;
        e = c + 8;
        expect_ce(e + 10, 16'd1);
        expect_ce(e + 20, 16'd2);
        expect_ce(e + 30, 16'd3);
        run_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n = 1'b1;
        wait_cyc(e + 41);
        check("bp_bp_hit", {31'd0, bp_hit}, 32'd1);
        check("bp_running", {31'd0, running}, 32'd0);
        check("bp_step_count", {16'd0, step_count}, 32'd3);
        c = cyc;
        e = c + 8;
        expect_ce(e + 10, 16'd4);
        expect_ce(e + 20, 16'd5);
        run_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n = 1'b1;
        wait_cyc(e + 2);
        check("resume_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("resume_running", {31'd0, running}, 32'd1);
        wait_cyc(e + 20);
        run_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n = 1'b1;
        wait_cyc(e + 35);
        check("resume_stop_running", {31'd0, running}, 32'd0);
        bp_en = 1'b0;

        // Simultaneous run+step: run wins, no immediate pulse; then wrap and reset in RUN.
        c = cyc;
        e = c + 8;
        expect_ce(e + 10, 16'd6);
        expect_ce(e + 20, 16'd0);
        run_btn_n  = 1'b0;
        step_btn_n = 1'b0;
        repeat (6) @(negedge clk);
        run_btn_n  = 1'b1;
        step_btn_n = 1'b1;
        wait_cyc(e);
        check("simul_running", {31'd0, running}, 32'd1);
        wait_cyc(e + 1);
        check("simul_step_count", {16'd0, step_count}, 32'd5);
        wait_cyc(e + 12);
        force dut.r_step_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_step_count;
        wait_cyc(e + 22);
        reset = 1'b1;
        @(negedge clk);
        check("rrun_running", {31'd0, running}, 32'd0);
        check("rrun_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("rrun_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("rrun_step_count", {16'd0, step_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rrun_after_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("rrun_after_running", {31'd0, running}, 32'd0);
        wait_cyc(e + 45);
        check("pending_expected", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution-control stage directly upstream of `control_unit`. It replaces the free-running divided clock with a one-cycle clock-enable pulse, `cpu_ce`, that drives the CPU from the 50 MHz domain. It debounces run/halt and single-step pushbuttons, paces steps at a selectable slow or fast rate, and halts execution on a PC breakpoint. Its status outputs feed `cpu_monitor` for display.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a debounced button level changes (20 ms at 50 MHz); must be ≥ 2.
- `SLOW_PERIOD`, 8_388_608: cycles between `cpu_ce` pulses in RUN when `fast_sw`=0; range 2 to 2^25.
- `FAST_PERIOD`, 1_048_576: cycles between `cpu_ce` pulses in RUN when `fast_sw`=1; range 2 to 2^25.
- `clk`  in  1  50 MHz system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `run_btn_n`  in  1  raw run/halt toggle button, active-low, asynchronous.
- `step_btn_n`  in  1  raw single-step button, active-low, asynchronous.
- `fast_sw`  in  1  raw rate-select switch, asynchronous.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  16  breakpoint PC value.
- `pc_in`  in  16  current CPU PC (`PC_out` of `control_unit`).
- `cpu_ce`  out  1  one-cycle CPU advance pulse.
- `running`  out  1  state is RUN.
- `bp_hit`  out  1  state is BREAK.
- `step_count`  out  16  count of issued `cpu_ce` pulses; wraps modulo 2^16.

## Operation
- Synchronisers: `run_btn_n`, `step_btn_n` and `fast_sw` each pass through 2 flops before any use.
- Debounce, per button:
  - The debounced level resets to 1 (released).
  - A counter increments while the synced input differs from the debounced level and clears whenever they agree.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, the debounced level takes the synced value and the counter clears.
  - A 1→0 transition of the debounced level produces a one-cycle press pulse. Releases produce no pulse.
- Pace counter: 25 bits. It clears on reset and on every entry to RUN. Active period = `fast_sw` (synced) ? `FAST_PERIOD` : `SLOW_PERIOD`.
- FSM states HALT, RUN, BREAK; reset state is HALT.
  - HALT:
    - step press → issue one `cpu_ce`; stay in HALT.
    - run press → go to RUN; clear the pace counter; clear `skip_bp`.
  - RUN:
    - The pace counter increments each cycle.
    - When the counter is ≥ period-1, evaluate the breakpoint:
      - If `bp_en` && `pc_in`==`bp_addr` && !`skip_bp` → no pulse; go to BREAK.
      - Otherwise → issue `cpu_ce`; clear the counter; clear `skip_bp`.
    - run press → go to HALT; any pending pulse that cycle is dropped.
    - step press → ignored.
  - BREAK:
    - step press → issue one `cpu_ce` (breakpoint not checked); go to HALT.
    - run press → go to RUN; clear the pace counter; set `skip_bp` so the first pace pulse passes the breakpoint.
- Simultaneous run and step press in one cycle: run wins and step is discarded.
- Changing `fast_sw` mid-count: the comparison uses ≥, so a counter already past the new period-1 fires on the next evaluation. There is no wrap glitch.
- `step_count` increments in the same cycle as each `cpu_ce` pulse.

## Timing
- Reset values: `cpu_ce`=0, `running`=0, `bp_hit`=0, `step_count`=0, debounced levels=1, all counters=0, `skip_bp`=0.
- Reset asserted mid-debounce or mid-RUN returns to HALT on the next edge. No `cpu_ce` is issued in the reset cycle or the cycle after.
- Press latency: from a stable low on the raw input, the press pulse occurs 2 (sync) + `DEBOUNCE_CYCLES` cycles later.
- `cpu_ce` and the state change are registered 1 cycle after the press pulse. `running`/`bp_hit` are decoded from registered state.
- RUN pacing:
  - The first `cpu_ce` comes `period` cycles after the RUN state is entered.
  - Subsequent pulses are exactly `period` cycles apart.
  - `cpu_ce` is never high for 2 consecutive cycles.
- Breakpoint compare uses `pc_in` sampled in the evaluation cycle. The CPU only changes PC after `cpu_ce`, so the compare is stable.

## Test plan
Params for all scenarios: `DEBOUNCE_CYCLES`=4, `SLOW_PERIOD`=10, `FAST_PERIOD`=3.
- Bounce rejection: toggle `step_btn_n` low/high every 2 cycles for 20 cycles, then release → no `cpu_ce`, `step_count`=0.
- Single step: hold `step_btn_n` low 10 cycles in HALT → exactly one `cpu_ce`, 7 cycles after the first low sample; `step_count`=1; `running`=0.
- Run pacing: press run with `fast_sw`=0 → `running`=1, `cpu_ce` every 10 cycles. Set `fast_sw`=1 → interval becomes 3 cycles within one period. After 5 pulses, press run → `running`=0 and pulses stop.
- Breakpoint: `bp_en`=1, `bp_addr`=0x0203. Model increments `pc_in` per `cpu_ce` starting at 0x0200; run → pulses at PC 0x0200–0x0202, then `bp_hit`=1, no pulse, `step_count`=3. Press run → next pulse is issued at PC 0x0203, `bp_hit`=0.
- Simultaneous press: run and step debounced in the same cycle from HALT → RUN entered, no immediate `cpu_ce`.
- Reset mid-run and wrap: preload 65535 pulses, issue one more → `step_count`=0. Assert `reset` in RUN → next cycle HALT, all outputs 0.
